// File: rtl/pe_types.sv
// Shared types and constants for the PE egress output monitor.
//   PE_MON_CNT_W / pe_mon_cnt_t : default beat/stall counter width and type
//   PE_MON_CRC_POLY / _INIT     : CRC-32 (MPEG-2 flavour, MSB first) constants
//   pe_mon_crc_bit()            : one-bit CRC shift step used by the optional
//                                 PE_MON_CRC_EN channel checksum
package pe_types;

    localparam int PE_MON_CNT_W = 32;
    typedef logic [PE_MON_CNT_W-1:0] pe_mon_cnt_t;

    localparam logic [31:0] PE_MON_CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] PE_MON_CRC_INIT = 32'hFFFF_FFFF;

    // Non-reflected CRC-32 step: feedback is the outgoing MSB XOR the input bit.
    function automatic logic [31:0] pe_mon_crc_bit(input logic [31:0] crc, input logic din);
        logic [31:0] shifted;
        shifted = {crc[30:0], 1'b0};
        if (crc[31] ^ din) begin
            return shifted ^ PE_MON_CRC_POLY;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/pe_mon_fifo.sv
// Capture FIFO for pe_out_mon: DEPTH x DATA_W synchronous FIFO.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   flush        : synchronous empty (pointers return to zero)
//   push, din    : write request; accepted when not full, or when a pop frees
//                  the head slot in the same cycle
//   pop          : remove head (ignored while empty)
//   dout         : head entry, forced to zero while empty
//   full, empty  : derived from pointers with one extra wrap bit
module pe_mon_fifo
    import pe_types::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              wr_s, rd_s;

    // Same low bits with differing wrap bit means the writer lapped the reader.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_s  = push && (!full || pop);
    assign rd_s  = pop && !empty;

    // Pointer next-state: flush wins, otherwise advance on accepted write/read.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care while empty, so it carries no reset.
    always_ff @(posedge clock) begin
        if (wr_s && !flush) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    // Head read, zero while empty so consumers never see stale data.
    always_comb begin
        dout = '0;
        if (empty) begin
            dout = '0;
        end else begin
            dout = mem_q[rptr_q[AW-1:0]];
        end
    end

endmodule

// File: rtl/pe_out_mon.sv
// Passive multi-channel egress monitor for PE array output streams.
//   ovalid/oready/odata : monitored handshakes (never driven)
//   clear               : sync clear of counters, errors, history and FIFO
//   cap_sel             : channel whose accepted beats feed the capture FIFO
//   cap_valid/ready/data: capture FIFO drain port; cap_ovf sticky drop flag
//   stat_ch             : selects stat_beats / stat_stalls (and stat_crc)
//   err / err_any       : sticky per-channel protocol violation flags
// Optional feature macro PE_MON_CRC_EN adds a per-channel CRC-32 over
// accepted beats and the stat_crc output port.
module pe_out_mon
    import pe_types::*;
#(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = PE_MON_CNT_W,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        ovalid,
    input  logic [NCH-1:0]        oready,
    input  logic [NCH*DATA_W-1:0] odata,
    input  logic                  clear,
    input  logic [SEL_W-1:0]      cap_sel,
    output logic                  cap_valid,
    input  logic                  cap_ready,
    output logic [DATA_W-1:0]     cap_data,
    output logic                  cap_ovf,
    input  logic [SEL_W-1:0]      stat_ch,
    output logic [CNT_W-1:0]      stat_beats,
    output logic [CNT_W-1:0]      stat_stalls,
    output logic [NCH-1:0]        err,
    output logic                  err_any
`ifdef PE_MON_CRC_EN
    ,
    output logic [31:0]           stat_crc
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NCH-1:0]    beat_vec_s;
    logic [DATA_W-1:0] data_arr_s   [NCH];
    logic [CNT_W-1:0]  beats_arr_s  [NCH];
    logic [CNT_W-1:0]  stalls_arr_s [NCH];
`ifdef PE_MON_CRC_EN
    logic [31:0]       crc_arr_s    [NCH];
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DATA_W-1:0] data_s;
        logic              beat_s, stall_s, viol_s;
        logic [CNT_W-1:0]  beats_q, beats_d, stalls_q, stalls_d;
        logic              err_q, err_d;
        logic              prev_stall_q, prev_stall_d;
        logic [DATA_W-1:0] prev_data_q, prev_data_d;

        assign data_s  = odata[c*DATA_W +: DATA_W];
        assign beat_s  = ovalid[c] && oready[c];
        assign stall_s = ovalid[c] && !oready[c];
        // A stalled beat must be offered again unchanged on the next cycle.
        assign viol_s  = prev_stall_q && (!ovalid[c] || (data_s != prev_data_q));

        // Counter, error and history next-state; clear overrides this cycle's events.
        always_comb begin
            beats_d      = beats_q;
            stalls_d     = stalls_q;
            err_d        = err_q;
            prev_stall_d = prev_stall_q;
            prev_data_d  = prev_data_q;
            if (clear) begin
                beats_d      = '0;
                stalls_d     = '0;
                err_d        = 1'b0;
                prev_stall_d = 1'b0;
                prev_data_d  = '0;
            end else begin
                if (beat_s && (beats_q != CNT_MAX)) begin
                    beats_d = beats_q + CNT_ONE;
                end else begin
                    beats_d = beats_q;
                end
                if (stall_s && (stalls_q != CNT_MAX)) begin
                    stalls_d = stalls_q + CNT_ONE;
                end else begin
                    stalls_d = stalls_q;
                end
                err_d        = err_q | viol_s;
                prev_stall_d = stall_s;
                prev_data_d  = data_s;
            end
        end

        // Per-channel state registers.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                beats_q      <= '0;
                stalls_q     <= '0;
                err_q        <= 1'b0;
                prev_stall_q <= 1'b0;
                prev_data_q  <= '0;
            end else begin
                beats_q      <= beats_d;
                stalls_q     <= stalls_d;
                err_q        <= err_d;
                prev_stall_q <= prev_stall_d;
                prev_data_q  <= prev_data_d;
            end
        end

`ifdef PE_MON_CRC_EN
        logic [31:0] crc_q, crc_d, crc_nxt_s;

        // CRC over the full beat, MSB first, only on accepted beats.
        always_comb begin
            crc_nxt_s = crc_q;
            for (int i = DATA_W - 1; i >= 0; i--) begin
                crc_nxt_s = pe_mon_crc_bit(crc_nxt_s, data_s[i]);
            end
            crc_d = crc_q;
            if (clear) begin
                crc_d = PE_MON_CRC_INIT;
            end else if (beat_s) begin
                crc_d = crc_nxt_s;
            end else begin
                crc_d = crc_q;
            end
        end

        // CRC register.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                crc_q <= PE_MON_CRC_INIT;
            end else begin
                crc_q <= crc_d;
            end
        end

        assign crc_arr_s[c] = crc_q;
`endif

        assign beat_vec_s[c]   = beat_s;
        assign data_arr_s[c]   = data_s;
        assign beats_arr_s[c]  = beats_q;
        assign stalls_arr_s[c] = stalls_q;
        assign err[c]          = err_q;
    end

    assign err_any = |err;

    // Stat readout mux; an out-of-range channel reads as zero.
    always_comb begin
        stat_beats  = '0;
        stat_stalls = '0;
`ifdef PE_MON_CRC_EN
        stat_crc    = PE_MON_CRC_INIT;
`endif
        if (int'(stat_ch) < NCH) begin
            stat_beats  = beats_arr_s[stat_ch];
            stat_stalls = stalls_arr_s[stat_ch];
`ifdef PE_MON_CRC_EN
            stat_crc    = crc_arr_s[stat_ch];
`endif
        end else begin
            stat_beats  = '0;
            stat_stalls = '0;
        end
    end

    // ------------------------------------------------------------------
    // Capture path
    // ------------------------------------------------------------------
    logic              cap_beat_s;
    logic [DATA_W-1:0] cap_din_s;
    logic              push_s, pop_s, drop_s;
    logic              fifo_full_s, fifo_empty_s;
    logic              cap_ovf_q, cap_ovf_d;

    // Route the selected channel's handshake into the FIFO write port.
    always_comb begin
        cap_beat_s = 1'b0;
        cap_din_s  = '0;
        if (int'(cap_sel) < NCH) begin
            cap_beat_s = beat_vec_s[cap_sel];
            cap_din_s  = data_arr_s[cap_sel];
        end else begin
            cap_beat_s = 1'b0;
            cap_din_s  = '0;
        end
    end

    assign push_s = cap_beat_s && !clear;
    assign pop_s  = cap_valid && cap_ready && !clear;
    // A pop in the same cycle frees the head slot, so only push-without-pop drops.
    assign drop_s = push_s && fifo_full_s && !pop_s;

    // Sticky overflow next-state.
    always_comb begin
        cap_ovf_d = cap_ovf_q;
        if (clear) begin
            cap_ovf_d = 1'b0;
        end else begin
            cap_ovf_d = cap_ovf_q | drop_s;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_ovf_q <= 1'b0;
        end else begin
            cap_ovf_q <= cap_ovf_d;
        end
    end

    assign cap_ovf   = cap_ovf_q;
    assign cap_valid = !fifo_empty_s;

    pe_mon_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clear),
        .push  (push_s),
        .pop   (pop_s),
        .din   (cap_din_s),
        .dout  (cap_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

endmodule

// File: tb/tb_pe_out_mon.sv
// Self-checking bench for pe_out_mon with a scoreboard model of the capture FIFO.
module tb_pe_out_mon;

    localparam int NCH    = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;
    localparam int SEL_W  = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NCH-1:0]        ovalid, oready;
    logic [NCH*DATA_W-1:0] odata;
    logic                  clear;
    logic [SEL_W-1:0]      cap_sel, stat_ch;
    logic                  cap_valid, cap_ready, cap_ovf, err_any;
    logic [DATA_W-1:0]     cap_data;
    logic [CNT_W-1:0]      stat_beats, stat_stalls;
    logic [NCH-1:0]        err;
`ifdef PE_MON_CRC_EN
    logic [31:0]           stat_crc;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int pop_cnt = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic ovf_exp = 1'b0;

    pe_out_mon #(.NCH(NCH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .ovalid      (ovalid),
        .oready      (oready),
        .odata       (odata),
        .clear       (clear),
        .cap_sel     (cap_sel),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .cap_data    (cap_data),
        .cap_ovf     (cap_ovf),
        .stat_ch     (stat_ch),
        .stat_beats  (stat_beats),
        .stat_stalls (stat_stalls),
        .err         (err),
        .err_any     (err_any)
`ifdef PE_MON_CRC_EN
        ,
        .stat_crc    (stat_crc)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_stats(input string tag, input logic [SEL_W-1:0] ch,
                             input int beats, input int stalls);
        stat_ch = ch;
        #1;
        check_val({tag, "_beats"}, 64'(stat_beats), 64'(beats));
        check_val({tag, "_stalls"}, 64'(stat_stalls), 64'(stalls));
    endtask

    task automatic drain(input string tag, input int n_exp);
        int start;
        int k;
        start = pop_cnt;
        k = 0;
        cap_ready = 1'b1;
        while (cap_valid && k < 60) begin
            tick();
            k++;
        end
        check_val({tag, "_in_time"}, 64'(k < 60), 64'(1));
        check_val({tag, "_pops"}, 64'(pop_cnt - start), 64'(n_exp));
        check_val({tag, "_empty"}, 64'(cap_valid), 64'(0));
    endtask

    // Scoreboard: model the FIFO from observed handshakes, compare on pops.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            ovf_exp = 1'b0;
        end else begin
            check_val("cap_valid", 64'(cap_valid), 64'(exp_q.size() != 0));
            check_val("cap_ovf", 64'(cap_ovf), 64'(ovf_exp));
            if (exp_q.size() == 0) begin
                check_val("cap_data_idle", 64'(cap_data), 64'(0));
            end
            if (clear) begin
                exp_q.delete();
                ovf_exp = 1'b0;
            end else begin
                if (cap_ready && exp_q.size() != 0) begin
                    check_val("cap_data", 64'(cap_data), 64'(exp_q.pop_front()));
                    pop_cnt++;
                end
                if (ovalid[cap_sel] && oready[cap_sel]) begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(odata[cap_sel*DATA_W +: DATA_W]);
                    end else begin
                        ovf_exp = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; ovalid = '0; oready = '0; odata = '0;
        cap_sel = '0; cap_ready = 1'b1; stat_ch = '0;
        repeat (2) tick();
        // Reset state
        chk_stats("rst_ch0", 2'd0, 0, 0);
        check_val("rst_err", 64'(err), 64'(0));
        check_val("rst_err_any", 64'(err_any), 64'(0));
        check_val("rst_cap_valid", 64'(cap_valid), 64'(0));
        check_val("rst_cap_data", 64'(cap_data), 64'(0));
        check_val("rst_cap_ovf", 64'(cap_ovf), 64'(0));
        reset = 1'b0;
        tick();

        // 1: ch0 five accepted beats (captured and drained, cap_sel = 0)
        ovalid[0] = 1'b1; oready[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            odata[0 +: DATA_W] = 32'(i + 32'h50);
            tick();
        end
        ovalid[0] = 1'b0; oready[0] = 1'b0;
        chk_stats("t1_ch0", 2'd0, 5, 0);
        check_val("t1_err", 64'(err), 64'(0));

        // 2: ch1 stalled three cycles with stable data, then accepted
        ovalid[1] = 1'b1; oready[1] = 1'b0; odata[DATA_W +: DATA_W] = 32'hA5;
        repeat (3) tick();
        oready[1] = 1'b1;
        tick();
        ovalid[1] = 1'b0; oready[1] = 1'b0;
        chk_stats("t2_ch1", 2'd1, 1, 3);
        check_val("t2_err", 64'(err), 64'(0));

        // 3: ch2 changes data while stalled
        ovalid[2] = 1'b1; oready[2] = 1'b0; odata[2*DATA_W +: DATA_W] = 32'h11;
        tick();
        check_val("t3_err_before", 64'(err), 64'(0));
        odata[2*DATA_W +: DATA_W] = 32'h22;
        tick();
        check_val("t3_err_set", 64'(err), 64'(4'b0100));
        check_val("t3_err_any", 64'(err_any), 64'(1));
        ovalid[2] = 1'b0;
        repeat (3) tick();
        check_val("t3_err_sticky", 64'(err), 64'(4'b0100));

        // 4: 17 beats into a 16-deep FIFO with no consumer
        cap_sel = 2'd3; cap_ready = 1'b0;
        ovalid[3] = 1'b1; oready[3] = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            odata[3*DATA_W +: DATA_W] = 32'(i);
            tick();
        end
        ovalid[3] = 1'b0; oready[3] = 1'b0;
        tick();
        check_val("t4_ovf", 64'(cap_ovf), 64'(1));
        chk_stats("t4_ch3_sat", 2'd3, 15, 0);
        drain("t4_drain", 16);

        // 5: full FIFO with push and pop together
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("t5_ovf_clr", 64'(cap_ovf), 64'(0));
        cap_ready = 1'b0;
        ovalid[3] = 1'b1; oready[3] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            odata[3*DATA_W +: DATA_W] = 32'(100 + i);
            tick();
        end
        odata[3*DATA_W +: DATA_W] = 32'd200;
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;
        ovalid[3] = 1'b0; oready[3] = 1'b0;
        tick();
        check_val("t5_ovf", 64'(cap_ovf), 64'(0));
        drain("t5_drain", 16);

        // 6: clear coincident with a ch0 beat, FIFO partly filled
        cap_ready = 1'b0;
        ovalid[3] = 1'b1; oready[3] = 1'b1;
        repeat (2) tick();
        ovalid[3] = 1'b0; oready[3] = 1'b0;
        cap_sel = 2'd0;
        ovalid[0] = 1'b1; oready[0] = 1'b1; odata[0 +: DATA_W] = 32'h0;
        clear = 1'b1;
        tick();
        clear = 1'b0; ovalid[0] = 1'b0; oready[0] = 1'b0;
        chk_stats("t6_ch0", 2'd0, 0, 0);
        chk_stats("t6_ch1", 2'd1, 0, 0);
        check_val("t6_err", 64'(err), 64'(0));
        check_val("t6_err_any", 64'(err_any), 64'(0));
        check_val("t6_cap_valid", 64'(cap_valid), 64'(0));
`ifdef PE_MON_CRC_EN
        stat_ch = 2'd0;
        #1;
        check_val("t6_crc_init", 64'(stat_crc), 64'(32'hFFFF_FFFF));
        cap_ready = 1'b1;
        ovalid[0] = 1'b1; oready[0] = 1'b1; odata[0 +: DATA_W] = 32'h0;
        tick();
        ovalid[0] = 1'b0; oready[0] = 1'b0;
        check_val("t6_crc_zero", 64'(stat_crc), 64'(32'hC704_DD7B));
        tick();
`endif

        // Reset asserted mid-operation with FIFO contents pending
        cap_sel = 2'd3; cap_ready = 1'b0;
        ovalid[3] = 1'b1; oready[3] = 1'b1;
        repeat (3) tick();
        ovalid[3] = 1'b0; oready[3] = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_mid_cap_valid", 64'(cap_valid), 64'(0));
        chk_stats("rst_mid_ch3", 2'd3, 0, 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
